// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and 640x480@60 defaults for the sync controller slice.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 11;

    function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int SEG_ACTIVE = DEF_H_ACTIVE,
    parameter int SEG_FP     = DEF_H_FP,
    parameter int SEG_SYNC   = DEF_H_SYNC,
    parameter int SEG_BP     = DEF_H_BP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output phase_t           phase
);

    localparam int TOTAL = seg_total(SEG_ACTIVE, SEG_FP, SEG_SYNC, SEG_BP);

    localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(SEG_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(SEG_ACTIVE + SEG_FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(SEG_ACTIVE + SEG_FP + SEG_SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);

    // Zero-length segments are never entered: each exit jumps to the next non-empty phase.
    localparam phase_t AFTER_SYNC   = (SEG_BP != 0)   ? BACK  : ACTIVE;
    localparam phase_t AFTER_FRONT  = (SEG_SYNC != 0) ? SYNC  : AFTER_SYNC;
    localparam phase_t AFTER_ACTIVE = (SEG_FP != 0)   ? FRONT : AFTER_FRONT;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_t           phase_q, phase_d;

    always_ff @(posedge div_clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap    = tick && (cnt_q == LAST_CNT);
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            unique case (phase_q)
                ACTIVE: if (cnt_q == LAST_ACT)  phase_d = AFTER_ACTIVE;
                FRONT:  if (cnt_q == LAST_FP)   phase_d = AFTER_FRONT;
                SYNC:   if (cnt_q == LAST_SYNC) phase_d = AFTER_SYNC;
                BACK:   if (cnt_q == LAST_CNT)  phase_d = ACTIVE;
                default:                        phase_d = ACTIVE;
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster sequencer with registered sync/enable/coordinate outputs.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_end,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    phase_t           h_phase, v_phase;
    logic             at_origin;

    vga_axis_timer #(
        .SEG_ACTIVE (H_ACTIVE),
        .SEG_FP     (H_FP),
        .SEG_SYNC   (H_SYNC),
        .SEG_BP     (H_BP),
        .CNT_W      (CNT_W)
    ) u_h_timer (
        .div_clk (div_clk),
        .rst     (rst),
        .tick    (en),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .phase   (h_phase)
    );

    vga_axis_timer #(
        .SEG_ACTIVE (V_ACTIVE),
        .SEG_FP     (V_FP),
        .SEG_SYNC   (V_SYNC),
        .SEG_BP     (V_BP),
        .CNT_W      (CNT_W)
    ) u_v_timer (
        .div_clk (div_clk),
        .rst     (rst),
        .tick    (h_wrap),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .phase   (v_phase)
    );

    // (0,0) is only ever reached through reset or a frame wrap, so track that instead of decoding both counters.
    always_ff @(posedge div_clk) begin
        if (rst) begin
            at_origin <= 1'b1;
        end else if (en) begin
            at_origin <= v_wrap;
        end
    end

    always_ff @(posedge div_clk) begin
        if (rst) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hsync_n     <= (h_phase != SYNC);
            vsync_n     <= (v_phase != SYNC);
            video_on    <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            line_end    <= (h_cnt == H_LAST);
            frame_start <= at_origin;
        end else begin
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Counts alongside frame_start so the value updates in the same cycle the marker appears.
    always_ff @(posedge div_clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (en && at_origin) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_controller.sv
// Self-checking bench: two small-raster instances against a position-based reference model.
module tb_vga_sync_controller;

    // Instance A: raster exactly fills its counter width; instance B: zero-length porches.
    localparam int A_HA = 4, A_HF = 1, A_HS = 2, A_HB = 1;
    localparam int A_VA = 3, A_VF = 1, A_VS = 1, A_VB = 1;
    localparam int A_W  = 3;
    localparam int B_HA = 6, B_HF = 0, B_HS = 3, B_HB = 0;
    localparam int B_VA = 4, B_VF = 0, B_VS = 1, B_VB = 2;
    localparam int B_W  = 4;
    localparam int A_FRAME = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);

    logic div_clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;

    logic a_hsync_n, a_vsync_n, a_video_on, a_line_end, a_frame_start;
    logic [A_W-1:0] a_pixel_x, a_pixel_y;
    logic b_hsync_n, b_vsync_n, b_video_on, b_line_end, b_frame_start;
    logic [B_W-1:0] b_pixel_x, b_pixel_y;
    logic [15:0] a_frame_cnt, b_frame_cnt;

    always #5 div_clk = ~div_clk;

    vga_sync_controller #(
        .H_ACTIVE (A_HA), .H_FP (A_HF), .H_SYNC (A_HS), .H_BP (A_HB),
        .V_ACTIVE (A_VA), .V_FP (A_VF), .V_SYNC (A_VS), .V_BP (A_VB),
        .CNT_W    (A_W)
    ) dut_a (
        .div_clk     (div_clk),
        .rst         (rst),
        .en          (en),
        .hsync_n     (a_hsync_n),
        .vsync_n     (a_vsync_n),
        .video_on    (a_video_on),
        .pixel_x     (a_pixel_x),
        .pixel_y     (a_pixel_y),
        .line_end    (a_line_end),
        .frame_start (a_frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (a_frame_cnt)
`endif
    );

    vga_sync_controller #(
        .H_ACTIVE (B_HA), .H_FP (B_HF), .H_SYNC (B_HS), .H_BP (B_HB),
        .V_ACTIVE (B_VA), .V_FP (B_VF), .V_SYNC (B_VS), .V_BP (B_VB),
        .CNT_W    (B_W)
    ) dut_b (
        .div_clk     (div_clk),
        .rst         (rst),
        .en          (en),
        .hsync_n     (b_hsync_n),
        .vsync_n     (b_vsync_n),
        .video_on    (b_video_on),
        .pixel_x     (b_pixel_x),
        .pixel_y     (b_pixel_y),
        .line_end    (b_line_end),
        .frame_start (b_frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (b_frame_cnt)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign a_frame_cnt = '0;
    assign b_frame_cnt = '0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: raster geometry, next position to present, expected outputs.
    int ha[2], hf[2], hs[2], hb[2], va[2], vf[2], vs[2], vb[2];
    int mx[2], my[2];
    logic e_hs[2], e_vs[2], e_vo[2], e_le[2], e_fs[2];
    int e_px[2], e_py[2], e_fc[2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                mx[i] = 0; my[i] = 0;
                e_hs[i] = 1'b1; e_vs[i] = 1'b1; e_vo[i] = 1'b0;
                e_px[i] = 0; e_py[i] = 0; e_le[i] = 1'b0; e_fs[i] = 1'b0; e_fc[i] = 0;
            end else if (e) begin
                e_hs[i] = !(mx[i] >= ha[i] + hf[i] && mx[i] < ha[i] + hf[i] + hs[i]);
                e_vs[i] = !(my[i] >= va[i] + vf[i] && my[i] < va[i] + vf[i] + vs[i]);
                e_vo[i] = (mx[i] < ha[i]) && (my[i] < va[i]);
                e_px[i] = mx[i];
                e_py[i] = my[i];
                e_le[i] = (mx[i] == ha[i] + hf[i] + hs[i] + hb[i] - 1);
                e_fs[i] = (mx[i] == 0) && (my[i] == 0);
                if (e_fs[i]) e_fc[i] = (e_fc[i] + 1) % 65536;
                mx[i] = mx[i] + 1;
                if (mx[i] == ha[i] + hf[i] + hs[i] + hb[i]) begin
                    mx[i] = 0;
                    my[i] = (my[i] + 1) % (va[i] + vf[i] + vs[i] + vb[i]);
                end
            end else begin
                e_le[i] = 1'b0;
                e_fs[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("A hsync_n",     16'(a_hsync_n),     16'(e_hs[0]));
        chk("A vsync_n",     16'(a_vsync_n),     16'(e_vs[0]));
        chk("A video_on",    16'(a_video_on),    16'(e_vo[0]));
        chk("A pixel_x",     16'(a_pixel_x),     16'(e_px[0]));
        chk("A pixel_y",     16'(a_pixel_y),     16'(e_py[0]));
        chk("A line_end",    16'(a_line_end),    16'(e_le[0]));
        chk("A frame_start", 16'(a_frame_start), 16'(e_fs[0]));
        chk("B hsync_n",     16'(b_hsync_n),     16'(e_hs[1]));
        chk("B vsync_n",     16'(b_vsync_n),     16'(e_vs[1]));
        chk("B video_on",    16'(b_video_on),    16'(e_vo[1]));
        chk("B pixel_x",     16'(b_pixel_x),     16'(e_px[1]));
        chk("B pixel_y",     16'(b_pixel_y),     16'(e_py[1]));
        chk("B line_end",    16'(b_line_end),    16'(e_le[1]));
        chk("B frame_start", 16'(b_frame_start), 16'(e_fs[1]));
`ifdef VGA_FRAME_CNT_EN
        chk("A frame_cnt",   a_frame_cnt,        16'(e_fc[0]));
        chk("B frame_cnt",   b_frame_cnt,        16'(e_fc[1]));
`endif
    endtask

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge div_clk);
        model_step(r, e);
        #1;
        compare_all();
    endtask

    initial begin
        ha[0] = A_HA; hf[0] = A_HF; hs[0] = A_HS; hb[0] = A_HB;
        va[0] = A_VA; vf[0] = A_VF; vs[0] = A_VS; vb[0] = A_VB;
        ha[1] = B_HA; hf[1] = B_HF; hs[1] = B_HS; hb[1] = B_HB;
        va[1] = B_VA; vf[1] = B_VF; vs[1] = B_VS; vb[1] = B_VB;
        model_step(1'b1, 1'b1);

        // Reset held with en high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("reset hsync_n", 16'(a_hsync_n), 16'd1);
        chk("reset video_on", 16'(a_video_on), 16'd0);

        // First en cycle after release presents the origin.
        step(1'b0, 1'b1);
        chk("start frame_start", 16'(a_frame_start), 16'd1);
        chk("start video_on", 16'(a_video_on), 16'd1);
        chk("start pixel_x", 16'(a_pixel_x), 16'd0);

        // Three complete frames with en held high.
        for (int i = 1; i < 3 * A_FRAME; i++) step(1'b0, 1'b1);
`ifdef VGA_FRAME_CNT_EN
        chk("three frames frame_cnt", a_frame_cnt, 16'd3);
`endif

        // en toggling every other cycle for two slowed frames.
        for (int i = 0; i < 4 * A_FRAME; i++) step(1'b0, 1'((i % 2) == 0));

        // Reset in the middle of a frame, then restart at the origin.
        for (int k = 0; k < 2 * A_FRAME && !(mx[0] == 2 && my[0] == 3); k++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midreset pixel_y", 16'(a_pixel_y), 16'd0);
        chk("midreset hsync_n", 16'(a_hsync_n), 16'd1);
        step(1'b0, 1'b1);
        chk("restart frame_start", 16'(a_frame_start), 16'd1);

        // Randomised en with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 250) == 0), 1'(($urandom % 4) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
